// File: rtl/gated_sr2_pkg.sv
// Shared types and next-state rule for the gated SR storage element.
package gated_sr2_pkg;

  // State encoding. 2'b11 is unused and recovers to ST_Q0.
  typedef enum logic [1:0] {
    ST_Q0        = 2'b00,
    ST_Q1        = 2'b01,
    ST_FORBIDDEN = 2'b10
  } state_e;

  // Next state from the current state and the gated S/R inputs.
  // An illegal encoding always goes to ST_Q0, even when the gate is closed.
  function automatic state_e next_state(
    input state_e state,
    input logic   en,
    input logic   s,
    input logic   r
  );
    state_e nxt;
    nxt = ST_Q0;
    case (state)
      ST_Q0, ST_Q1, ST_FORBIDDEN: begin
        if (!en) begin
          nxt = state;
        end else begin
          case ({s, r})
            // Idle inputs hold, but a captured S=R=1 resolves to reset,
            // making the NOR latch race deterministic.
            2'b00:   nxt = (state == ST_FORBIDDEN) ? ST_Q0 : state;
            2'b10:   nxt = ST_Q1;
            2'b01:   nxt = ST_Q0;
            default: nxt = ST_FORBIDDEN;
          endcase
        end
      end
      default: nxt = ST_Q0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/gated_sr2_decode.sv
// Combinational decode of the state register into Q, Qbar and invalid.
module gated_sr2_decode
  import gated_sr2_pkg::*;
(
  input  state_e i_state,
  output logic   o_q,
  output logic   o_qbar,
  output logic   o_invalid
);

  // Map each state to its output triple; unused encodings read as ST_Q0.
  always_comb begin
    // NOTE: every output gets a value before the case so no path leaves one
    // unassigned, which would infer a latch.
    o_q       = 1'b0;
    o_qbar    = 1'b1;
    o_invalid = 1'b0;
    case (i_state)
      ST_Q1: begin
        o_q    = 1'b1;
        o_qbar = 1'b0;
      end
      ST_FORBIDDEN: begin
        o_q       = 1'b0;
        o_qbar    = 1'b0;
        o_invalid = 1'b1;
      end
      default: begin
        o_q       = 1'b0;
        o_qbar    = 1'b1;
        o_invalid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/gated_sr2.sv
// Clocked, enable-gated SR storage element modelling a NOR gated SR latch,
// including the S=R=1 forbidden condition as an explicit state.
module gated_sr2
  import gated_sr2_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic R,
  input  logic S,
  input  logic EN,
  output logic Q,
  output logic Qbar,
  output logic invalid
);

  state_e r_state;
  state_e w_next_state;

  // Next-state logic from the registered state and the sampled inputs.
  always_comb begin
    w_next_state = next_state(r_state, EN, S, R);
  end

  // State register; reset forces ST_Q0 asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      r_state <= ST_Q0;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Outputs depend only on the state register, never directly on inputs.
  gated_sr2_decode u_decode (
    .i_state   (r_state),
    .o_q       (Q),
    .o_qbar    (Qbar),
    .o_invalid (invalid)
  );

endmodule

// File: tb/tb_gated_sr2.sv
// Self-checking bench for gated_sr2: a vector table of single-edge steps
// plus hand-written sequences for reset and between-edge behaviour.
module tb_gated_sr2;

  logic clk;
  logic rst_n;
  logic R;
  logic S;
  logic EN;
  logic Q;
  logic Qbar;
  logic invalid;

  int checks = 0;
  int errors = 0;

  // Expected output triples {Q, Qbar, invalid}.
  localparam logic [2:0] O_Q0 = 3'b010;
  localparam logic [2:0] O_Q1 = 3'b100;
  localparam logic [2:0] O_FB = 3'b001;

  typedef struct {
    string      name;
    logic       en;
    logic       s;
    logic       r;
    logic [2:0] exp;
  } vec_t;

  vec_t vecs[$];

  gated_sr2 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .R       (R),
    .S       (S),
    .EN      (EN),
    .Q       (Q),
    .Qbar    (Qbar),
    .invalid (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the stimulus is a fixed short sequence.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach summary, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {Q,Qbar,invalid}=%b expected %b", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, clock once, sample 1 ns after the edge.
  task automatic step(input logic en, input logic s, input logic r);
    @(negedge clk);
    EN = en;
    S  = s;
    R  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string name, input logic en, input logic s,
                     input logic r, input logic [2:0] exp);
    vec_t v;
    v.name = name;
    v.en   = en;
    v.s    = s;
    v.r    = r;
    v.exp  = exp;
    vecs.push_back(v);
  endtask

  initial begin
    // Sequential table, starting from the reset state Q0.
    add("hold0_a",       1, 0, 0, O_Q0);
    add("hold0_b",       1, 0, 0, O_Q0);
    add("set",           1, 1, 0, O_Q1);
    add("reset",         1, 0, 1, O_Q0);
    add("forbid",        1, 1, 1, O_FB);
    add("forbid_resolve",1, 0, 0, O_Q0);
    add("set2",          1, 1, 0, O_Q1);
    add("gate_00",       0, 0, 0, O_Q1);
    add("gate_01",       0, 0, 1, O_Q1);
    add("gate_10",       0, 1, 0, O_Q1);
    add("gate_11",       0, 1, 1, O_Q1);
    add("forbid2",       1, 1, 1, O_FB);
    add("forbid_gate00", 0, 0, 0, O_FB);
    add("forbid_gate10", 0, 1, 0, O_FB);
    add("forbid_to_q0",  1, 0, 1, O_Q0);
    add("forbid3",       1, 1, 1, O_FB);
    add("forbid_to_q1",  1, 1, 0, O_Q1);
    add("q1_to_forbid",  1, 1, 1, O_FB);
    add("forbid_gate01", 0, 0, 1, O_FB);
    add("forbid_reset",  1, 0, 1, O_Q0);
    add("q0_gate_set",   0, 1, 0, O_Q0);

    // Reset with active inputs, including across a clock edge.
    rst_n = 1'b0;
    EN = 1'b1;
    S  = 1'b1;
    R  = 1'b0;
    #2;
    check("reset_hold", {Q, Qbar, invalid}, O_Q0);
    @(posedge clk);
    #1;
    check("reset_over_edge", {Q, Qbar, invalid}, O_Q0);
    @(negedge clk);
    EN = 1'b0;
    S  = 1'b0;
    rst_n = 1'b1;

    // Table-driven single-edge steps.
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].s, vecs[i].r);
      check(vecs[i].name, {Q, Qbar, invalid}, vecs[i].exp);
    end

    // Inputs toggled between edges have no effect: from Q1, pulse R and
    // S=R=1 with EN=1 mid-cycle, restore idle inputs before the edge.
    step(1, 1, 0);
    check("mid_pre_q1", {Q, Qbar, invalid}, O_Q1);
    #1;
    R = 1'b1;
    #1;
    S = 1'b1;
    #1;
    check("mid_no_transparency", {Q, Qbar, invalid}, O_Q1);
    S = 1'b0;
    R = 1'b0;
    @(posedge clk);
    #1;
    check("mid_edge_idle", {Q, Qbar, invalid}, O_Q1);

    // Asynchronous reset during FORBIDDEN, asserted mid-cycle.
    step(1, 1, 1);
    check("pre_async_forbid", {Q, Qbar, invalid}, O_FB);
    EN = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_forbid", {Q, Qbar, invalid}, O_Q0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_gated", {Q, Qbar, invalid}, O_Q0);

    // Asynchronous reset from Q1, then the first edge after release acts.
    step(1, 1, 0);
    check("pre_async_q1", {Q, Qbar, invalid}, O_Q1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_q1", {Q, Qbar, invalid}, O_Q0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 1, 0);
    check("first_edge_after_release", {Q, Qbar, invalid}, O_Q1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gated_sr2.md
# gated_sr2

Clocked, enable-gated set/reset storage element that reproduces NOR-based gated SR latch behaviour, including the forbidden S=R=1 condition. Used wherever a set/reset flag with an enable qualifier is needed, e.g. sticky status bits or control flags in small control paths. All state changes are synchronous to one clock. The block has an asynchronous active-low reset.

## Interface
- No parameters.
- clk   input  1  rising-edge clock; all state updates occur on this edge.
- rst_n input  1  asynchronous, active-low reset.
- R     input  1  reset request; clears Q when EN=1.
- S     input  1  set request; sets Q when EN=1.
- EN    input  1  gate enable; when 0, S and R are ignored.
- Q     output 1  stored value.
- Qbar  output 1  complementary output. Equals ~Q except in the FORBIDDEN state.
- invalid output 1  high while the element is in the FORBIDDEN state (S=R=1 captured).

## Operation
- Three-state machine:
  - Q0: Q=0, Qbar=1, invalid=0.
  - Q1: Q=1, Qbar=0, invalid=0.
  - FORBIDDEN: Q=0, Qbar=0, invalid=1. This mirrors the NOR latch with both inputs high.
- Transitions at a clk rising edge when EN=1:
  - S=0, R=0: hold the current state. In FORBIDDEN, go to Q0 instead, which resolves the NOR race deterministically to reset.
  - S=1, R=0: go to Q1.
  - S=0, R=1: go to Q0.
  - S=1, R=1: go to FORBIDDEN.
- When EN=0, hold the current state, including FORBIDDEN. No transition occurs regardless of S and R.
- Outputs are a pure decode of the state register. There is no combinational path from inputs to outputs.
- Unused state encodings recover to Q0 on the next clock edge.

## Timing
- Reset:
  - rst_n low forces Q0 immediately, independent of clk.
  - Resulting outputs: Q=0, Qbar=1, invalid=0.
  - Reset asserted mid-operation, including in FORBIDDEN, overrides everything.
- Release: rst_n deassertion is synchronised by the integrator. The first state update occurs on the first rising edge with rst_n=1.
- Latency: one cycle. Inputs sampled at edge N are reflected on the outputs after edge N.
- Input changes between edges have no effect; there is no level-transparent path.
- Simultaneous S=R=1 with EN=0 has no effect.

## Structure
- Shared package `gated_sr2_pkg` holds:
  - the state enum: Q0=2'b00, Q1=2'b01, FORBIDDEN=2'b10, with 2'b11 unused;
  - a next-state function taking (state, EN, S, R).
- One natural sub-module, `gated_sr2_decode`: combinational state-to-(Q, Qbar, invalid) decoder. The top holds the state register plus the next-state logic.

## Test plan
- Reset: hold rst_n=0 with any S/R/EN -> Q=0, Qbar=1, invalid=0; check again asynchronously mid-cycle.
- Hold after reset: EN=1, S=0, R=0 for 2 cycles -> Q=0, Qbar=1.
- Set then reset: EN=1, S=1, R=0, one edge -> Q=1, Qbar=0; then S=0, R=1, one edge -> Q=0, Qbar=1.
- Forbidden:
  - EN=1, S=1, R=1, one edge -> Q=0, Qbar=0, invalid=1.
  - Then S=0, R=0, one edge -> Q=0, Qbar=1, invalid=0.
- Gate closed: from Q1, EN=0 and toggle S/R through all 4 combinations over 4 edges -> Q stays 1, Qbar stays 0.
- Reset during FORBIDDEN: enter FORBIDDEN, pulse rst_n low mid-cycle -> outputs go to Q=0, Qbar=1, invalid=0 before the next edge.
